// File: rtl/riscy_pkg.sv
// riscy_pkg: shared definitions for the RISC-y accumulator processor.
//   - width constants for data, address and instruction words
//   - opcode enum (INSTR[15:12]) and control FSM state enum
//   - is_load(): true for the two opcodes that need the extra MEM cycle
package riscy_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDAI = 4'h1,
        OP_LDBI = 4'h2,
        OP_LDA  = 4'h3,
        OP_LDB  = 4'h4,
        OP_STA  = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_OUT  = 4'hD,
        OP_IN   = 4'hE,
        OP_DIR  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_e;

    function automatic logic is_load(input opcode_e op);
        return (op == OP_LDA) || (op == OP_LDB);
    endfunction

endpackage

// File: rtl/riscy_alu.sv
// riscy_alu: combinational 8-bit ALU selected by the opcode.
//   op : current opcode, en : output enable (result forced to 0 when low)
//   a/b: operands, y : result (modulo 256, no flags)
module riscy_alu
    import riscy_pkg::*;
(
    input  opcode_e           op,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            case (op)
                OP_ADD:  y = a + b;
                OP_SUB:  y = a - b;
                OP_AND:  y = a & b;
                OP_OR:   y = a | b;
                OP_XOR:  y = a ^ b;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: rtl/riscy_ctrl.sv
// riscy_ctrl: FETCH/EXEC/MEM sequencer and strobe decode.
//   clk/rst : clock, synchronous active-high reset
//   op      : opcode of the instruction held in INSTR
//   a_zero  : A == 0, used by JZ in EXEC
//   outputs : datapath strobes, all low by default and all low while rst is high
module riscy_ctrl
    import riscy_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_e op,
    input  logic    a_zero,
    output logic    ir_en,
    output logic    a_en,
    output logic    b_en,
    output logic    pdr_en,
    output logic    port_en,
    output logic    port_rd,
    output logic    pc_en,
    output logic    pc_load,
    output logic    alu_en,
    output logic    alu_oe,
    output logic    ram_oe,
    output logic    ram_cs,
    output logic    rdr_en
);

    state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= EXEC;
                EXEC:    state <= is_load(op) ? MEM : FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes are decoded from the current state so that the FETCH cycle right
    // after reset release already loads ROM[0]; gating by rst guarantees that
    // an aborted instruction cannot write RAM or registers.
    always_comb begin
        ir_en   = 1'b0;
        a_en    = 1'b0;
        b_en    = 1'b0;
        pdr_en  = 1'b0;
        port_en = 1'b0;
        port_rd = 1'b0;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        alu_en  = 1'b0;
        alu_oe  = 1'b0;
        ram_oe  = 1'b0;
        ram_cs  = 1'b0;
        rdr_en  = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    ir_en = 1'b1;
                    pc_en = 1'b1;
                end
                EXEC: begin
                    case (op)
                        OP_LDAI: a_en = 1'b1;
                        OP_IN: begin
                            a_en    = 1'b1;
                            port_rd = 1'b1;
                        end
                        OP_LDBI: b_en = 1'b1;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            alu_en = 1'b1;
                            alu_oe = 1'b1;
                            a_en   = 1'b1;
                        end
                        OP_LDA, OP_LDB: begin
                            ram_cs = 1'b1;
                            ram_oe = 1'b1;
                            rdr_en = 1'b1;
                        end
                        OP_STA:  ram_cs  = 1'b1;
                        OP_JMP:  pc_load = 1'b1;
                        OP_JZ:   pc_load = a_zero;
                        OP_OUT:  port_en = 1'b1;
                        OP_DIR:  pdr_en  = 1'b1;
                        default: ;
                    endcase
                end
                MEM: begin
                    ram_oe = 1'b1;
                    if (op == OP_LDA) begin
                        a_en = 1'b1;
                    end else begin
                        b_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riscy_ram.sv
// riscy_ram: data memory, asynchronous read, synchronous write.
//   cs/oe  : a write happens on the clock edge when cs is high and oe is low
//   addr   : byte address, wdata/rdata : write and read data
// Contents are deliberately not reset.
module riscy_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          oe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] MEM [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (cs && !oe) begin
            MEM[addr] <= wdata;
        end
    end

    assign rdata = MEM[addr];

endmodule

// File: rtl/riscy_rom.sv
// riscy_rom: instruction store with combinational read.
//   clk        : clock for the program-load port
//   load_en    : write load_data into MEM[load_addr] (tied off inside the CPU;
//                programs are normally preloaded into MEM directly)
//   addr/data  : asynchronous instruction read port
module riscy_rom #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] MEM [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (load_en) begin
            MEM[load_addr] <= load_data;
        end
    end

    assign data = MEM[addr];

endmodule

// File: rtl/riscy_cpu.sv
// riscy_cpu: top of the RISC-y multi-cycle accumulator processor.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   IO  : 8-bit bidirectional port, driven with PORT_DATA when DIRECTION=1
//         and no IN is reading it, otherwise high-Z
// Datapath registers (PC, INSTR, A, B, RDR, PORT_DATA, DIRECTION) live here;
// the upper-case internal names are probed by benches and must not change.
module riscy_cpu
    import riscy_pkg::*;
#(
    parameter int ROM_DEPTH = 256,
    parameter int RAM_DEPTH = 256
) (
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [DATA_W-1:0] IO
);

    logic [INSTR_W-1:0] ROM_OUT;
    logic [ADDR_W-1:0]  ROM_ADDR;
    logic [INSTR_W-1:0] INSTR;
    logic [DATA_W-1:0]  RAM_OUT;
    logic [DATA_W-1:0]  RAM_DATA;
    logic               DIRECTION;
    logic [DATA_W-1:0]  PORT_DATA;
    logic [DATA_W-1:0]  A;
    logic [DATA_W-1:0]  B;
    logic [DATA_W-1:0]  ALU_OUT;
    logic [DATA_W-1:0]  DATA;
    logic [ADDR_W-1:0]  PC;
    logic [DATA_W-1:0]  RDR;

    logic IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD;
    logic ALU_EN, ALU_OE, RAM_OE, RAM_CS, RDR_EN;

    opcode_e           op;
    logic [ADDR_W-1:0] imm;
    logic              unused_instr_bits;

    assign op                = opcode_e'(INSTR[15:12]);
    assign imm               = INSTR[ADDR_W-1:0];
    assign unused_instr_bits = ^INSTR[11:8];
    assign ROM_ADDR          = PC;
    assign RAM_DATA          = A;

    riscy_rom #(.DEPTH(ROM_DEPTH), .AW(ADDR_W), .DW(INSTR_W)) ROM (
        .clk       (CLK),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_data ('0),
        .addr      (ROM_ADDR),
        .data      (ROM_OUT)
    );

    riscy_ram #(.DEPTH(RAM_DEPTH), .AW(ADDR_W), .DW(DATA_W)) RAM (
        .clk   (CLK),
        .cs    (RAM_CS),
        .oe    (RAM_OE),
        .addr  (imm),
        .wdata (RAM_DATA),
        .rdata (RAM_OUT)
    );

    riscy_alu ALU (
        .op (op),
        .en (ALU_EN),
        .a  (A),
        .b  (B),
        .y  (ALU_OUT)
    );

    riscy_ctrl CTRL (
        .clk     (CLK),
        .rst     (RST),
        .op      (op),
        .a_zero  (A == '0),
        .ir_en   (IR_EN),
        .a_en    (A_EN),
        .b_en    (B_EN),
        .pdr_en  (PDR_EN),
        .port_en (PORT_EN),
        .port_rd (PORT_RD),
        .pc_en   (PC_EN),
        .pc_load (PC_LOAD),
        .alu_en  (ALU_EN),
        .alu_oe  (ALU_OE),
        .ram_oe  (RAM_OE),
        .ram_cs  (RAM_CS),
        .rdr_en  (RDR_EN)
    );

    // Internal bus. RDR is only selected once it has been loaded, i.e. in the
    // MEM cycle where RAM_OE stays high but RDR_EN has dropped.
    always_comb begin
        if (ALU_OE) begin
            DATA = ALU_OUT;
        end else if (RAM_OE && !RDR_EN) begin
            DATA = RDR;
        end else if (PORT_RD) begin
            DATA = IO;
        end else if (op == OP_OUT || op == OP_STA) begin
            DATA = A;
        end else begin
            DATA = imm;
        end
    end

    assign IO = (DIRECTION && !PORT_RD) ? PORT_DATA : 'z;

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC        <= '0;
            INSTR     <= '0;
            A         <= '0;
            B         <= '0;
            RDR       <= '0;
            PORT_DATA <= '0;
            DIRECTION <= 1'b0;
        end else begin
            if (PC_LOAD) begin
                PC <= imm;
            end else if (PC_EN) begin
                PC <= PC + ADDR_W'(1);
            end
            if (IR_EN)   INSTR     <= ROM_OUT;
            if (A_EN)    A         <= DATA;
            if (B_EN)    B         <= DATA;
            if (RDR_EN)  RDR       <= RAM_OUT;
            if (PORT_EN) PORT_DATA <= DATA;
            if (PDR_EN)  DIRECTION <= DATA[0];
        end
    end

endmodule

// File: tb/tb_riscy_cpu.sv
// tb_riscy_cpu: directed programs for riscy_cpu checked against an
// instruction-level model (architectural registers, RAM array, per-opcode
// cycle counts) plus hand-computed literal expectations.
module tb_riscy_cpu;

    logic       CLK    = 1'b0;
    logic       RST    = 1'b1;
    logic       io_en  = 1'b0;
    logic [7:0] io_val = 8'h00;
    wire  [7:0] io_bus;

    assign io_bus = io_en ? io_val : 8'hzz;

    riscy_cpu dut (
        .CLK (CLK),
        .RST (RST),
        .IO  (io_bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prog  [256];
    logic [7:0]  m_ram [256];
    logic [7:0]  m_pc  = 8'h00;
    logic [7:0]  m_a   = 8'h00;
    logic [7:0]  m_b   = 8'h00;
    logic [7:0]  m_pd  = 8'h00;
    logic        m_dir = 1'b0;
    logic [15:0] cur    = 16'h0000;
    logic [7:0]  cur_pc = 8'h00;
    logic [3:0]  cur_op;
    logic [7:0]  cur_imm;
    int          phase = 0;
    int          lat   = 2;
    logic        rst_seen = 1'b1;

    wire [12:0] strobes = {dut.IR_EN, dut.A_EN, dut.B_EN, dut.PDR_EN, dut.PORT_EN,
                           dut.PORT_RD, dut.PC_EN, dut.PC_LOAD, dut.ALU_EN,
                           dut.ALU_OE, dut.RAM_OE, dut.RAM_CS, dut.RDR_EN};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] imm);
        return {op, 4'h0, imm};
    endfunction

    always @(posedge CLK) rst_seen <= RST;

    // Instruction-level model: an instruction starts with a fetch cycle, takes
    // 2 cycles (3 for LDA/LDB) and commits its effect at the end of its last
    // cycle unless reset is pending for the coming edge.
    always @(negedge CLK) begin
        if (rst_seen) begin
            m_pc  = 8'h00;
            m_a   = 8'h00;
            m_b   = 8'h00;
            m_pd  = 8'h00;
            m_dir = 1'b0;
            phase = 0;
        end
        if (RST) begin
            chk("strobes_in_reset", strobes, 0);
        end else if (phase == 0) begin
            chk("pc", dut.ROM_ADDR, m_pc);
            chk("a", dut.A, m_a);
            chk("b", dut.B, m_b);
            chk("port_data", dut.PORT_DATA, m_pd);
            chk("direction", dut.DIRECTION, m_dir);
            chk("fetch_ir_en", dut.IR_EN, 1);
            chk("fetch_pc_en", dut.PC_EN, 1);
            chk("fetch_pc_load", dut.PC_LOAD, 0);
            if (m_dir) chk("io_out", io_bus, m_pd);
            else if (io_en) chk("io_in_undriven", io_bus, io_val);
            cur     = prog[m_pc];
            cur_pc  = m_pc;
            cur_op  = cur[15:12];
            cur_imm = cur[7:0];
            m_pc    = m_pc + 8'd1;
            lat     = (cur_op == 4'h3 || cur_op == 4'h4) ? 3 : 2;
            phase   = 1;
        end else begin
            chk("instr", dut.INSTR, cur);
            chk("pc_en_and_load", dut.PC_EN & dut.PC_LOAD, 0);
            if (phase == 1 && (cur_op == 4'h3 || cur_op == 4'h4))
                chk("exec_rdr_en", dut.RDR_EN, 1);
            if (phase == 1 && cur_op == 4'hE)
                chk("exec_port_rd", dut.PORT_RD, 1);
            phase++;
            if (phase == lat) begin
                case (cur_op)
                    4'h1: m_a = cur_imm;
                    4'h2: m_b = cur_imm;
                    4'h3: m_a = m_ram[cur_imm];
                    4'h4: m_b = m_ram[cur_imm];
                    4'h5: m_ram[cur_imm] = m_a;
                    4'h6: m_a = m_a + m_b;
                    4'h7: m_a = m_a - m_b;
                    4'h8: m_a = m_a & m_b;
                    4'h9: m_a = m_a | m_b;
                    4'hA: m_a = m_a ^ m_b;
                    4'hB: m_pc = cur_imm;
                    4'hC: if (m_a == 8'h00) m_pc = cur_imm;
                    4'hD: m_pd = m_a;
                    4'hE: m_a = io_val;
                    4'hF: m_dir = cur_imm[0];
                    default: ;
                endcase
                $display("retire pc=%02h instr=%04h A=%02h B=%02h PD=%02h DIR=%0d",
                         cur_pc, cur, m_a, m_b, m_pd, m_dir);
                phase = 0;
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.ROM.MEM[i] = prog[i];
    endtask

    task automatic reset_on();
        @(posedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
    endtask

    task automatic reset_off();
        @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;

        // Arithmetic program, loaded under a 10-cycle reset.
        clear_prog();
        prog[0]  = ins(4'h1, 8'h05);
        prog[1]  = ins(4'h2, 8'h03);
        prog[2]  = ins(4'h6, 8'h00);
        prog[3]  = ins(4'h7, 8'h00);
        prog[4]  = ins(4'h1, 8'h02);
        prog[5]  = ins(4'h2, 8'h05);
        prog[6]  = ins(4'h7, 8'h00);
        prog[7]  = ins(4'h2, 8'h0F);
        prog[8]  = ins(4'h8, 8'h00);
        prog[9]  = ins(4'h9, 8'h00);
        prog[10] = ins(4'h2, 8'h3C);
        prog[11] = ins(4'hA, 8'h00);
        prog[12] = ins(4'hB, 8'h0C);
        load_prog();
        repeat (10) @(posedge CLK);
        #3;
        chk("rst_pc", dut.PC, 0);
        chk("rst_a", dut.A, 0);
        chk("rst_b", dut.B, 0);
        chk("rst_dir", dut.DIRECTION, 0);
        chk("rst_instr", dut.INSTR, 0);
        chk("rst_strobes", strobes, 0);
        reset_off();
        wait_cyc(1);
        chk("first_fetch_instr", dut.INSTR, 16'h1005);
        chk("first_fetch_pc", dut.PC, 1);
        wait_cyc(5);
        chk("add_a", dut.A, 8'h08);
        chk("model_add_a", m_a, 8'h08);
        wait_cyc(2);
        chk("sub_a", dut.A, 8'h05);
        wait_cyc(6);
        chk("sub_wrap_a", dut.A, 8'hFD);
        chk("model_sub_wrap_a", m_a, 8'hFD);
        wait_cyc(12);
        chk("logic_a", dut.A, 8'h33);
        chk("logic_b", dut.B, 8'h3C);

        // Memory program: store, then load back into A and B.
        reset_on();
        clear_prog();
        prog[0] = ins(4'h1, 8'hA5);
        prog[1] = ins(4'h5, 8'h10);
        prog[2] = ins(4'h1, 8'h00);
        prog[3] = ins(4'h3, 8'h10);
        prog[4] = ins(4'h4, 8'h10);
        prog[5] = ins(4'hB, 8'h05);
        load_prog();
        reset_off();
        wait_cyc(4);
        chk("sta_ram", dut.RAM.MEM[16], 8'hA5);
        wait_cyc(2);
        chk("ldai0_a", dut.A, 8'h00);
        wait_cyc(2);
        chk("lda_after_2cyc", dut.A, 8'h00);
        wait_cyc(1);
        chk("lda_after_3cyc", dut.A, 8'hA5);
        chk("model_lda_a", m_a, 8'hA5);
        wait_cyc(3);
        chk("ldb_b", dut.B, 8'hA5);

        // Reset during the EXEC cycle of STA aborts the write.
        reset_on();
        clear_prog();
        prog[0] = ins(4'h1, 8'h5A);
        prog[1] = ins(4'h5, 8'h10);
        prog[2] = ins(4'hB, 8'h02);
        load_prog();
        reset_off();
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        #3;
        chk("abort_pc", dut.PC, 0);
        chk("abort_ram", dut.RAM.MEM[16], 8'hA5);
        reset_off();
        wait_cyc(4);
        chk("rerun_ram", dut.RAM.MEM[16], 8'h5A);

        // Output port.
        reset_on();
        clear_prog();
        prog[0] = ins(4'hF, 8'h01);
        prog[1] = ins(4'h1, 8'h3C);
        prog[2] = ins(4'hD, 8'h00);
        prog[3] = ins(4'hF, 8'h00);
        prog[4] = ins(4'hB, 8'h04);
        load_prog();
        reset_off();
        wait_cyc(6);
        chk("out_io", io_bus, 8'h3C);
        chk("out_dir", dut.DIRECTION, 1);
        wait_cyc(2);
        chk("dir0_dir", dut.DIRECTION, 0);
        chk("dir0_port_data", dut.PORT_DATA, 8'h3C);

        // Input port.
        reset_on();
        io_val = 8'h81;
        io_en  = 1'b1;
        clear_prog();
        prog[0] = ins(4'hE, 8'h00);
        prog[1] = ins(4'hB, 8'h01);
        load_prog();
        reset_off();
        wait_cyc(2);
        chk("in_a", dut.A, 8'h81);
        wait_cyc(4);

        // Control flow: taken JZ, untaken JZ, jump to 0xFF and PC wrap.
        reset_on();
        io_en = 1'b0;
        clear_prog();
        prog[8'h00] = ins(4'h1, 8'h00);
        prog[8'h01] = ins(4'hC, 8'h20);
        prog[8'h20] = ins(4'h1, 8'h01);
        prog[8'h21] = ins(4'hC, 8'h40);
        prog[8'h22] = ins(4'hB, 8'hFF);
        prog[8'hFF] = ins(4'h2, 8'h99);
        load_prog();
        reset_off();
        wait_cyc(4);
        chk("jz_taken_pc", dut.PC, 8'h20);
        wait_cyc(4);
        chk("jz_not_taken_pc", dut.PC, 8'h22);
        chk("jz_not_taken_a", dut.A, 8'h01);
        wait_cyc(2);
        chk("jmp_pc", dut.PC, 8'hFF);
        wait_cyc(2);
        chk("wrap_pc", dut.PC, 8'h00);
        chk("wrap_b", dut.B, 8'h99);
        chk("model_wrap_pc", m_pc, 8'h00);
        wait_cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
